// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : flash_loader
// Purpose  : UART (8N1) boot loader. Receives a framed image
//            (SYNC, LEN_HI, LEN_LO, payload, CHK), strobes each payload byte
//            toward the core's flash port and holds the core until the
//            image checksum has been verified.
// Revision : 1.0 - initial release
// ============================================================================
module flash_loader #(
    parameter int       CLKS_PER_BIT = 868,
    parameter int       MAX_BYTES    = 4096,
    parameter int       TIMEOUT_CLKS = 1000000,
    parameter bit [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        flashEn,
    output logic [7:0]  flashInstruction,
    output logic        cpuHold,
    output logic        loadDone,
    output logic        loadError,
    output logic [15:0] byteCount
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] c_tmr_last  = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [15:0]      c_max_bytes = 16'(MAX_BYTES);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR
    } state_t;

    // ---------------- UART receiver ----------------
    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;
    logic            w_start_edge;

    // Falling edge of the synchronized line while the receiver is idle.
    assign w_start_edge = (rx_state_q == RX_IDLE) && rxd_prev_q && !rxd_sync_q;

    // Two-flop synchronizer plus edge history; line idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Receiver bit-timing state machine: mid-bit sampling, LSB first.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (w_start_edge) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == c_half_last) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_state_d = RX_IDLE;
                    if (rxd_sync_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_shift_q;
                    end else begin
                        rx_ferr_d  = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ---------------- Frame state machine ----------------
    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             flash_en_q, flash_en_d;
    logic [7:0]       flash_instr_q, flash_instr_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             load_done_q, load_done_d;
    logic             load_error_q, load_error_d;
    logic [15:0]      byte_count_q, byte_count_d;
    logic             w_in_frame, w_timeout;

    assign w_in_frame = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    // A byte arriving in the same cycle as expiry wins over the timeout.
    assign w_timeout  = w_in_frame && !rx_valid_q && !w_start_edge &&
                        (timer_q == c_tmr_last);

    // Next-state, status and strobe generation for the frame parser.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        sum_d         = sum_q;
        flash_en_d    = 1'b0;
        flash_instr_d = flash_instr_q;
        cpu_hold_d    = cpu_hold_q;
        load_done_d   = load_done_q;
        load_error_d  = load_error_q;
        byte_count_d  = byte_count_q;
        timer_d       = '0;
        if (w_in_frame && !rx_valid_q && !w_start_edge)
            timer_d = timer_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_q && rx_byte_q == SYNC_BYTE) begin
                    cpu_hold_d   = 1'b1;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    byte_count_d = '0;
                    sum_d        = '0;
                    state_d      = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid_q) begin
                    len_d   = {rx_byte_q, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid_q) begin
                    len_d = {len_q[15:8], rx_byte_q};
                    if (len_d > c_max_bytes) state_d = S_ERROR;
                    else if (len_d == 16'd0) state_d = S_CHECK;
                    else                     state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid_q) begin
                    flash_en_d    = 1'b1;
                    flash_instr_d = rx_byte_q;
                    sum_d         = sum_q + rx_byte_q;
                    if (byte_count_q < c_max_bytes)
                        byte_count_d = byte_count_q + 16'd1;
                    if (byte_count_q + 16'd1 >= len_q)
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rx_valid_q)
                    state_d = (rx_byte_q == sum_q) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                load_done_d = 1'b1;
                cpu_hold_d  = 1'b0;
                state_d     = S_IDLE;
            end
            S_ERROR: begin
                load_error_d = 1'b1;
                cpu_hold_d   = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Line errors and stalls abort the frame; a strobe already
        // scheduled above for this cycle is still issued.
        if (w_in_frame && (rx_ferr_q || w_timeout))
            state_d = S_ERROR;
    end

    // Frame parser registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            sum_q         <= '0;
            timer_q       <= '0;
            flash_en_q    <= 1'b0;
            flash_instr_q <= '0;
            cpu_hold_q    <= 1'b0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
            byte_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            timer_q       <= timer_d;
            flash_en_q    <= flash_en_d;
            flash_instr_q <= flash_instr_d;
            cpu_hold_q    <= cpu_hold_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
            byte_count_q  <= byte_count_d;
        end
    end

    assign flashEn          = flash_en_q;
    assign flashInstruction = flash_instr_q;
    assign cpuHold          = cpu_hold_q;
    assign loadDone         = load_done_q;
    assign loadError        = load_error_q;
    assign byteCount        = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_loader
// Purpose  : Directed bench for flash_loader. Payload bytes are queued as
//            they are sent and matched against each flashEn strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic        flashEn;
    logic [7:0]  flashInstruction;
    logic        cpuHold;
    logic        loadDone;
    logic        loadError;
    logic [15:0] byteCount;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_strobes = 0;
    int          strobes_before = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_byte;

    flash_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_BYTES(16),
        .TIMEOUT_CLKS(2000),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .flashEn(flashEn),
        .flashInstruction(flashInstruction),
        .cpuHold(cpuHold),
        .loadDone(loadDone),
        .loadError(loadError),
        .byteCount(byteCount)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest outstanding payload byte.
    always @(negedge clk) begin
        if (reset && flashEn === 1'b1) begin
            n_strobes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL strobe_unexpected: observed %0h required none", flashInstruction);
            end else begin
                exp_byte = exp_q.pop_front();
                assert (flashInstruction === exp_byte) else begin
                    n_err++;
                    $error("FAIL strobe_byte: observed %0h required %0h", flashInstruction, exp_byte);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(CPB);
        end
        rxd = stop_bit;
        wait_clks(CPB);
        rxd = 1'b1;
        wait_clks(6);
    endtask

    task automatic send_hdr(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_data(input logic [7:0] b);
        exp_q.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic check_strobes(input string tag, input int n);
        chk(tag, n_strobes - strobes_before, n);
        chk({tag, "_drained"}, exp_q.size(), 0);
        strobes_before = n_strobes;
    endtask

    initial begin
        // Reset state
        wait_clks(3);
        chk("rst_outputs", {flashEn, flashInstruction, cpuHold, loadDone, loadError, byteCount}, 0);
        reset = 1'b1;
        wait_clks(5);

        // 1. Good 4-byte frame
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h04);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        wait_clks(20);
        chk("t1_hold_before_chk", cpuHold, 1);
        chk("t1_count", byteCount, 4);
        chk("t1_done_before_chk", loadDone, 0);
        send_hdr(8'h13);
        wait_clks(20);
        chk("t1_done", loadDone, 1);
        chk("t1_error", loadError, 0);
        chk("t1_hold", cpuHold, 0);
        check_strobes("t1_strobes", 4);

        // 2. Bad checksum, then good resend
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h04);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        send_hdr(8'h14);
        wait_clks(20);
        chk("t2_error", loadError, 1);
        chk("t2_done", loadDone, 0);
        chk("t2_hold", cpuHold, 1);
        check_strobes("t2_strobes", 4);
        send_hdr(8'hA5);
        wait_clks(4);
        chk("t2_sync_clears_error", loadError, 0);
        send_hdr(8'h00); send_hdr(8'h04);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        send_hdr(8'h13);
        wait_clks(20);
        chk("t2_resend_done", {loadDone, loadError, cpuHold}, 3'b100);
        check_strobes("t2_resend_strobes", 4);

        // 3. Length above MAX_BYTES
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h11);
        wait_clks(20);
        chk("t3_error", {loadDone, loadError, cpuHold}, 3'b011);
        check_strobes("t3_strobes", 0);

        // 4. Junk ignored, then empty frame
        send_hdr(8'h3C); send_hdr(8'h5A);
        wait_clks(20);
        chk("t4_junk_ignored", {loadDone, loadError, cpuHold}, 3'b011);
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h00); send_hdr(8'h00);
        wait_clks(20);
        chk("t4_done", {loadDone, loadError, cpuHold}, 3'b100);
        chk("t4_count", byteCount, 0);
        check_strobes("t4_strobes", 0);

        // 5a. Inter-byte timeout after first payload byte
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h02);
        send_data(8'hFF);
        wait_clks(1900);
        chk("t5_no_early_timeout", loadError, 0);
        wait_clks(200);
        chk("t5_timeout_error", {loadDone, loadError, cpuHold}, 3'b011);
        chk("t5_timeout_count", byteCount, 1);
        check_strobes("t5_strobes", 1);

        // 5b. Zero stop bit on a payload byte
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h02);
        send_byte(8'h42, 1'b0);
        wait_clks(20);
        chk("t5_ferr_error", {loadDone, loadError, cpuHold}, 3'b011);
        chk("t5_ferr_count", byteCount, 0);
        check_strobes("t5_ferr_strobes", 0);

        // 6. Reset mid-payload
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h04);
        send_data(8'h13); send_data(8'h27);
        check_strobes("t6_pre_reset_strobes", 2);
        reset = 1'b0;
        #1;
        chk("t6_reset_outputs", {flashEn, flashInstruction, cpuHold, loadDone, loadError, byteCount}, 0);
        wait_clks(4);
        reset = 1'b1;
        wait_clks(4);
        send_hdr(8'hA5); send_hdr(8'h00); send_hdr(8'h04);
        // Short low glitch inside the frame must not become a payload byte.
        rxd = 1'b0;
        wait_clks(4);
        rxd = 1'b1;
        wait_clks(40);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        send_hdr(8'h13);
        wait_clks(20);
        chk("t6_reload_done", {loadDone, loadError, cpuHold}, 3'b100);
        chk("t6_reload_count", byteCount, 4);
        check_strobes("t6_reload_strobes", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
